// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter: regfile writeback arbiter between the main pipeline and a     |
// | buffered multi-cycle unit, with starvation guard and pending scoreboard.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_wa,
    input  logic [63:0] pipe_wd,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wa,
    input  logic [63:0] mdu_wd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy1,
    output logic        busy2,
    output logic        wen,
    output logic [4:0]  wa,
    output logic [63:0] wd
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_wa_q [FIFO_DEPTH];
    logic [63:0]   fifo_wd_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          force_head;
    logic          push;
    logic          grant_head;
    logic          grant_pipe;
    logic [4:0]    head_wa;
    logic [63:0]   head_wd;
    logic [31:0]   inflight;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign force_head = !fifo_empty && (starve_q == LIMIT_C);

    // A forced head pop is decided purely by registered state, so a full
    // FIFO can still accept a push in that cycle without any input-to-ready path.
    assign mdu_ready  = !fifo_full || force_head;
    assign push       = !reset && mdu_valid && mdu_ready;

    assign grant_head = !reset && !fifo_empty && (force_head || !pipe_valid);
    assign grant_pipe = !reset && pipe_valid && !force_head;
    assign head_wa    = fifo_wa_q[rd_ptr_q];
    assign head_wd    = fifo_wd_q[rd_ptr_q];

    always_comb begin
        wa = '0;
        wd = '0;
        if (grant_head) begin
            wa = head_wa;
            wd = head_wd;
        end else if (grant_pipe) begin
            wa = pipe_wa;
            wd = pipe_wd;
        end
        wen        = (grant_head || grant_pipe) && (wa != '0);
        pipe_stall = !reset && pipe_valid && !grant_pipe;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(grant_head);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(grant_head);

        if (grant_head || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        // Set is applied after clear so a same-cycle issue to the retiring register wins.
        pending_d = pending_q;
        if (grant_head) begin
            pending_d[head_wa] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        inflight = pending_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                inflight[fifo_wa_q[rd_ptr_q + AW'(i)]] = 1'b1;
            end
        end
        if (push) begin
            inflight[mdu_wa] = 1'b1;
        end
    end

    assign busy1 = !reset && (rs1 != '0) && inflight[rs1];
    assign busy2 = !reset && (rs2 != '0) && inflight[rs2];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa_q[wr_ptr_q] <= mdu_wa;
            fifo_wd_q[wr_ptr_q] <= mdu_wd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter: directed vector table plus randomized reference model.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_wa;
    logic [63:0] pipe_wd;
    logic        pipe_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_wa;
    logic [63:0] mdu_wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy1;
    logic        busy2;
    logic        wen;
    logic [4:0]  wa;
    logic [63:0] wd;

    always #5 clk = ~clk;

    wb_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_wa    (pipe_wa),
        .pipe_wd    (pipe_wd),
        .pipe_stall (pipe_stall),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_wa     (mdu_wa),
        .mdu_wd     (mdu_wd),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .busy1      (busy1),
        .busy2      (busy2),
        .wen        (wen),
        .wa         (wa),
        .wd         (wd)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [4:0]  pwa;
        logic [63:0] pwd;
        logic        mv;
        logic [4:0]  mwa;
        logic [63:0] mwd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic        e_stall;
        logic        e_ready;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    typedef struct {
        logic [4:0]  wa;
        logic [63:0] wd;
    } ent_t;

    vec_t        vecs[$];
    ent_t        mq[$];
    int          head_wait;
    logic [31:0] pend;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic pv, input logic [4:0] pwa, input logic [63:0] pwd,
                       input logic mv, input logic [4:0] mwa, input logic [63:0] mwd,
                       input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
                       input logic ewen, input logic [4:0] ewa, input logic [63:0] ewd,
                       input logic estall, input logic eready, input logic eb1, input logic eb2);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pwa = pwa; v.pwd = pwd;
        v.mv = mv; v.mwa = mwa; v.mwd = mwd; v.iv = iv; v.ird = ird;
        v.r1 = r1; v.r2 = r2;
        v.e_wen = ewen; v.e_wa = ewa; v.e_wd = ewd; v.e_stall = estall;
        v.e_ready = eready; v.e_b1 = eb1; v.e_b2 = eb2;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic pv, input logic [4:0] pwa, input logic [63:0] pwd,
                         input logic mv, input logic [4:0] mwa, input logic [63:0] mwd,
                         input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; pipe_valid = pv; pipe_wa = pwa; pipe_wd = pwd;
        mdu_valid = mv; mdu_wa = mwa; mdu_wd = mwd;
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    endtask

    function automatic logic model_busy(input logic [4:0] r, input logic push, input logic [4:0] mwa);
        logic hit;
        hit = pend[r] || (push && mwa == r);
        foreach (mq[k]) if (mq[k].wa == r) hit = 1'b1;
        return (r != 5'd0) && hit;
    endfunction

    initial begin
        // Directed cycle-by-cycle scenarios
        add(1, 1,3,64'h1,    1,4,64'h4,     0,0,  4,3,  0,0,64'h0,0,1,0,0);
        add(0, 1,5,64'hAA,   0,0,64'h0,     0,0,  0,0,  1,5,64'hAA,0,1,0,0);
        add(0, 0,0,64'h0,    1,7,64'h1234,  0,0,  7,0,  0,0,64'h0,0,1,1,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  7,0,  1,7,64'h1234,0,1,1,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  7,0,  0,0,64'h0,0,1,0,0);
        add(0, 1,1,64'h11,   1,6,64'h66,    0,0,  0,6,  1,1,64'h11,0,1,0,1);
        for (int i = 0; i < 4; i++)
            add(0, 1,2,64'h22, 0,0,64'h0,   0,0,  6,0,  1,2,64'h22,0,1,1,0);
        add(0, 1,2,64'h22,   0,0,64'h0,     0,0,  6,0,  1,6,64'h66,1,1,1,0);
        add(0, 1,2,64'h22,   0,0,64'h0,     0,0,  6,0,  1,2,64'h22,0,1,0,0);
        add(0, 1,3,64'h33,   1,8,64'h88,    0,0,  0,0,  1,3,64'h33,0,1,0,0);
        add(0, 1,3,64'h33,   1,10,64'hA0,   0,0,  8,10, 1,3,64'h33,0,1,1,1);
        add(0, 1,3,64'h33,   1,11,64'hB0,   0,0,  11,10,1,3,64'h33,0,0,0,1);
        for (int i = 0; i < 2; i++)
            add(0, 1,3,64'h33, 0,0,64'h0,   0,0,  0,0,  1,3,64'h33,0,0,0,0);
        add(0, 1,3,64'h33,   1,12,64'hC0,   0,0,  12,8, 1,8,64'h88,1,1,1,1);
        add(0, 1,3,64'h33,   0,0,64'h0,     0,0,  0,8,  1,3,64'h33,0,0,0,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  10,12,1,10,64'hA0,0,0,1,1);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  10,12,1,12,64'hC0,0,1,0,1);
        add(0, 0,0,64'h0,    0,0,64'h0,     1,9,  9,0,  0,0,64'h0,0,1,0,0);
        add(0, 0,0,64'h0,    1,9,64'h99,    0,0,  9,0,  0,0,64'h0,0,1,1,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  9,0,  1,9,64'h99,0,1,1,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  9,0,  0,0,64'h0,0,1,0,0);
        add(0, 0,0,64'h0,    1,0,64'hDEAD,  1,0,  0,0,  0,0,64'h0,0,1,0,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  0,0,  0,0,64'hDEAD,0,1,0,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  0,0,  0,0,64'h0,0,1,0,0);
        add(0, 1,4,64'h44,   1,13,64'h1,    0,0,  0,0,  1,4,64'h44,0,1,0,0);
        add(0, 1,4,64'h44,   1,14,64'h2,    0,0,  13,0, 1,4,64'h44,0,1,1,0);
        add(1, 1,4,64'h44,   0,0,64'h0,     0,0,  13,14,0,0,64'h0,0,0,0,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  13,14,0,0,64'h0,0,1,0,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  0,0,  0,0,64'h0,0,1,0,0);
        add(0, 0,0,64'h0,    1,15,64'hF,    0,0,  15,0, 0,0,64'h0,0,1,1,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     1,15, 15,0, 1,15,64'hF,0,1,1,0);
        add(0, 0,0,64'h0,    0,0,64'h0,     0,0,  15,0, 0,0,64'h0,0,1,1,0);

        drive(1, 0,0,64'h0, 0,0,64'h0, 0,0, 0,0);
        @(posedge clk); #1;

        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].rst, vecs[v].pv, vecs[v].pwa, vecs[v].pwd, vecs[v].mv, vecs[v].mwa,
                  vecs[v].mwd, vecs[v].iv, vecs[v].ird, vecs[v].r1, vecs[v].r2);
            #3;
            check($sformatf("vec%0d.wen", v),   64'(wen),        64'(vecs[v].e_wen));
            check($sformatf("vec%0d.wa", v),    64'(wa),         64'(vecs[v].e_wa));
            check($sformatf("vec%0d.wd", v),    wd,              vecs[v].e_wd);
            check($sformatf("vec%0d.stall", v), 64'(pipe_stall), 64'(vecs[v].e_stall));
            check($sformatf("vec%0d.ready", v), 64'(mdu_ready),  64'(vecs[v].e_ready));
            check($sformatf("vec%0d.busy1", v), 64'(busy1),      64'(vecs[v].e_b1));
            check($sformatf("vec%0d.busy2", v), 64'(busy2),      64'(vecs[v].e_b2));
            @(posedge clk); #1;
        end

        // Randomized traffic against the queue-based reference model
        mq.delete();
        head_wait = 0;
        pend      = '0;
        for (int c = 0; c < 2000; c++) begin
            logic        r_rst, r_pv, r_mv, r_iv;
            logic [4:0]  r_pwa, r_mwa, r_ird, r_r1, r_r2;
            logic [63:0] r_pwd, r_mwd;
            logic        forced, ready, gh, gp, push, was_empty;
            logic        e_wen, e_stall, e_b1, e_b2;
            logic [4:0]  e_wa;
            logic [63:0] e_wd;

            r_rst = (c == 0) || ($urandom_range(0, 99) == 0);
            r_pv  = ($urandom_range(0, 9) < 7);
            r_pwa = 5'($urandom_range(0, 31));
            r_pwd = {32'($urandom), 32'($urandom)};
            r_mv  = ($urandom_range(0, 1) == 1);
            r_mwa = 5'($urandom_range(0, 15));
            r_mwd = {32'($urandom), 32'($urandom)};
            r_ird = 5'($urandom_range(0, 15));
            r_iv  = ($urandom_range(0, 3) == 0) && !pend[r_ird];
            r_r1  = 5'($urandom_range(0, 15));
            r_r2  = 5'($urandom_range(0, 15));
            drive(r_rst, r_pv, r_pwa, r_pwd, r_mv, r_mwa, r_mwd, r_iv, r_ird, r_r1, r_r2);
            #3;

            forced = (mq.size() > 0) && (head_wait == LIMIT);
            ready  = (mq.size() < DEPTH) || forced;
            gh     = !r_rst && (mq.size() > 0) && (forced || !r_pv);
            gp     = !r_rst && r_pv && !forced;
            push   = !r_rst && r_mv && ready;
            e_wa   = gh ? mq[0].wa : (gp ? r_pwa : 5'd0);
            e_wd   = gh ? mq[0].wd : (gp ? r_pwd : 64'd0);
            e_wen  = (gh || gp) && (e_wa != 5'd0);
            e_stall = !r_rst && r_pv && !gp;
            e_b1   = !r_rst && model_busy(r_r1, push, r_mwa);
            e_b2   = !r_rst && model_busy(r_r2, push, r_mwa);

            check($sformatf("rnd%0d.wen", c),   64'(wen),        64'(e_wen));
            check($sformatf("rnd%0d.wa", c),    64'(wa),         64'(e_wa));
            check($sformatf("rnd%0d.wd", c),    wd,              e_wd);
            check($sformatf("rnd%0d.stall", c), 64'(pipe_stall), 64'(e_stall));
            check($sformatf("rnd%0d.ready", c), 64'(mdu_ready),  64'(ready));
            check($sformatf("rnd%0d.busy1", c), 64'(busy1),      64'(e_b1));
            check($sformatf("rnd%0d.busy2", c), 64'(busy2),      64'(e_b2));

            if (r_rst) begin
                mq.delete();
                head_wait = 0;
                pend      = '0;
            end else begin
                was_empty = (mq.size() == 0);
                if (gh) begin
                    pend[mq[0].wa] = 1'b0;
                    void'(mq.pop_front());
                end
                if (r_iv && r_ird != 5'd0) pend[r_ird] = 1'b1;
                if (push) mq.push_back('{wa: r_mwa, wd: r_mwd});
                if (gh || was_empty) head_wait = 0;
                else if (head_wait < LIMIT) head_wait = head_wait + 1;
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
